// File: rtl/aes_round_ctrl.sv
// Round sequencer for the AES transform datapath: drives subbyte/columnmix start pulses,
// the addroundkey strobe and round index, and flags a timeout if a stage never reports ready.
module aes_round_ctrl #(
  parameter int NR      = 10,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_in,
  input  logic       en_de_in,
  input  logic       sub_ready_in,
  input  logic       colmix_ready_in,
  output logic       sub_start_out,
  output logic       colmix_start_out,
  output logic       ark_en_out,
  output logic       load_sel_out,
  output logic [3:0] round_out,
  output logic       en_de_out,
  output logic       busy_out,
  output logic       done_out,
  output logic       error_out
);

  localparam logic [3:0] NR_L    = 4'(NR);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, ARK0, SUB_GO, SUB_WAIT, MIX_GO, MIX_WAIT, ARK, DONE
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] r_q, r_d;
  logic [7:0] cnt_q, cnt_d;
  logic       en_de_q, en_de_d;
  logic       error_q, error_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      cnt_q   <= '0;
      en_de_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      en_de_q <= en_de_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    en_de_d = en_de_q;
    error_d = error_q;
    unique case (state_q)
      IDLE: begin
        if (start_in) begin
          state_d = ARK0;
          en_de_d = en_de_in;
          r_d     = '0;
          error_d = 1'b0;
        end
      end
      ARK0: begin
        r_d     = 4'd1;
        state_d = SUB_GO;
      end
      SUB_GO: begin
        cnt_d   = '0;
        state_d = SUB_WAIT;
      end
      // sub_ready_in has priority; colmix_ready_in is meaningless here
      SUB_WAIT: begin
        if (sub_ready_in) begin
          state_d = (r_q < NR_L) ? MIX_GO : ARK;
        end else if (cnt_q == TO_LAST) begin
          error_d = 1'b1;
          r_d     = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      MIX_GO: begin
        cnt_d   = '0;
        state_d = MIX_WAIT;
      end
      MIX_WAIT: begin
        if (colmix_ready_in) begin
          state_d = ARK;
        end else if (cnt_q == TO_LAST) begin
          error_d = 1'b1;
          r_d     = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ARK: begin
        if (r_q == NR_L) begin
          state_d = DONE;
        end else begin
          r_d     = r_q + 4'd1;
          state_d = SUB_GO;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sub_start_out    = 1'b0;
    colmix_start_out = 1'b0;
    ark_en_out       = 1'b0;
    load_sel_out     = 1'b0;
    done_out         = 1'b0;
    busy_out         = (state_q != IDLE);
    en_de_out        = en_de_q;
    error_out        = error_q;
    round_out        = '0;
    if (state_q != IDLE) begin
      round_out = en_de_q ? r_q : (NR_L - r_q);
    end
    unique case (state_q)
      ARK0: begin
        ark_en_out   = 1'b1;
        load_sel_out = 1'b1;
      end
      SUB_GO:  sub_start_out    = 1'b1;
      MIX_GO:  colmix_start_out = 1'b1;
      ARK:     ark_en_out       = 1'b1;
      DONE:    done_out         = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Scoreboard bench for aes_round_ctrl: the driver queues expected ARK/DONE/ERR events,
// a negedge monitor pops and compares them as the DUT emits strobes.
module tb_aes_round_ctrl;
  localparam int NR      = 10;
  localparam int EV_ARK  = 0;
  localparam int EV_DONE = 1;
  localparam int EV_ERR  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_in = 1'b0;
  logic       en_de_in = 1'b0;
  logic       sub_ready_in = 1'b0;
  logic       colmix_ready_in = 1'b0;
  logic       sub_start_out, colmix_start_out, ark_en_out, load_sel_out;
  logic [3:0] round_out;
  logic       en_de_out, busy_out, done_out, error_out;

  aes_round_ctrl #(.NR(NR), .TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n), .start_in(start_in), .en_de_in(en_de_in),
    .sub_ready_in(sub_ready_in), .colmix_ready_in(colmix_ready_in),
    .sub_start_out(sub_start_out), .colmix_start_out(colmix_start_out),
    .ark_en_out(ark_en_out), .load_sel_out(load_sel_out), .round_out(round_out),
    .en_de_out(en_de_out), .busy_out(busy_out), .done_out(done_out), .error_out(error_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int cyc;
    int rnd;
    int lsel;
    int ende;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;
  int   dly = 1;
  int   hold_round = -1;
  bit   spur = 1'b0;
  int   sub_tmr = 0;
  int   mix_tmr = 0;
  int   mix_cnt = 0;
  int   ark_cnt = 0;
  logic prev_err = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Cycle of the ARK strobe for round r, counted from the start cycle, readies d cycles after GO
  function automatic int ark_cyc(input int r, input int d);
    if (r == 0) return 1;
    if (r < NR) return 1 + (2 * d + 3) * r;
    return 1 + (2 * d + 3) * (NR - 1) + d + 2;
  endfunction

  task automatic push_ev(input int kind, input int c, input int rnd, input int lsel, input int ende);
    exp_t e;
    e.kind = kind; e.cyc = c; e.rnd = rnd; e.lsel = lsel; e.ende = ende;
    sb.push_back(e);
  endtask

  // stop_round > NR: full block; otherwise only rounds below stop_round commit
  task automatic push_block(input int b, input int dir, input int d, input int stop_round, input bit to);
    for (int r = 0; r <= NR && r < stop_round; r++)
      push_ev(EV_ARK, b + ark_cyc(r, d), (dir != 0) ? r : NR - r, (r == 0) ? 1 : 0, dir);
    if (stop_round > NR)
      push_ev(EV_DONE, b + ark_cyc(NR, d) + 1, (dir != 0) ? NR : 0, 0, dir);
    else if (to)
      push_ev(EV_ERR, b + 2 + (2 * d + 3) * (stop_round - 1) + 1 + 255, 0, 0, dir);
  endtask

  task automatic start_block(input int dir, input int d, input int stop_round, input bit to);
    push_block(cyc, dir, d, stop_round, to);
    start_in = 1'b1;
    en_de_in = (dir != 0);
    @(posedge clk); #1;
    start_in = 1'b0;
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while (sb.size() != 0 && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    chk("scoreboard_drained", sb.size(), 0);
    sb.delete();
  endtask

  task automatic pop_exp(input int kind, output bit ok, output exp_t e);
    ok = 1'b0;
    e.kind = -1; e.cyc = 0; e.rnd = 0; e.lsel = 0; e.ende = 0;
    if (sb.size() == 0) begin
      chk("unexpected_event", kind, -1);
    end else begin
      e = sb.pop_front();
      chk("event_kind", kind, e.kind);
      ok = (e.kind == kind);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sub_start"}, int'(sub_start_out), 0);
    chk({tag, "_colmix_start"}, int'(colmix_start_out), 0);
    chk({tag, "_ark_en"}, int'(ark_en_out), 0);
    chk({tag, "_load_sel"}, int'(load_sel_out), 0);
    chk({tag, "_round"}, int'(round_out), 0);
    chk({tag, "_en_de"}, int'(en_de_out), 0);
    chk({tag, "_busy"}, int'(busy_out), 0);
    chk({tag, "_done"}, int'(done_out), 0);
    chk({tag, "_error"}, int'(error_out), 0);
  endtask

  // Ready responder: answers each GO after dly cycles; optional stall and spurious colmix ready
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sub_tmr = 0; mix_tmr = 0;
        sub_ready_in = 1'b0; colmix_ready_in = 1'b0;
      end else begin
        sub_ready_in    = (sub_tmr == 1);
        colmix_ready_in = (mix_tmr == 1) || (spur && (sub_tmr == 3 || sub_tmr == 1));
        if (sub_tmr > 0) sub_tmr--;
        if (mix_tmr > 0) mix_tmr--;
        if (sub_start_out && int'(round_out) != hold_round) sub_tmr = dly;
        if (colmix_start_out) mix_tmr = dly;
      end
    end
  end

  // Monitor
  initial begin
    exp_t e;
    bit   ok;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mix_cnt = 0; ark_cnt = 0; prev_err = 1'b0;
      end else begin
        if (colmix_start_out) mix_cnt++;
        if (ark_en_out) begin
          if (load_sel_out) begin
            mix_cnt = 0; ark_cnt = 0;
          end
          ark_cnt++;
          pop_exp(EV_ARK, ok, e);
          if (ok) begin
            chk("ark_cycle", cyc, e.cyc);
            chk("ark_round", int'(round_out), e.rnd);
            chk("ark_load_sel", int'(load_sel_out), e.lsel);
            chk("ark_en_de", int'(en_de_out), e.ende);
            chk("ark_error_clear", int'(error_out), 0);
          end
        end
        if (done_out) begin
          pop_exp(EV_DONE, ok, e);
          if (ok) begin
            chk("done_cycle", cyc, e.cyc);
            chk("done_round", int'(round_out), e.rnd);
            chk("colmix_pulses", mix_cnt, NR - 1);
            chk("ark_pulses", ark_cnt, NR + 1);
            chk("busy_at_done", int'(busy_out), 1);
          end
        end
        if (error_out && !prev_err) begin
          pop_exp(EV_ERR, ok, e);
          if (ok) begin
            chk("error_cycle", cyc, e.cyc);
            chk("error_busy", int'(busy_out), 0);
            chk("error_round", int'(round_out), 0);
            chk("error_no_done", int'(done_out), 0);
          end
        end
        prev_err = error_out;
      end
    end
  end

  initial begin
    int b;
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", int'(busy_out), 0);

    // encrypt, readies one cycle after each GO
    start_block(1, 1, NR + 1, 1'b0);
    drain(100);

    // decrypt, same stimulus
    start_block(0, 1, NR + 1, 1'b0);
    drain(100);

    // stall subbyte in round 3 until timeout
    hold_round = 3;
    start_block(1, 1, 3, 1'b1);
    drain(400);
    hold_round = -1;
    repeat (2) @(posedge clk);
    #1;
    chk("error_sticky", int'(error_out), 1);
    chk("error_idle_busy", int'(busy_out), 0);
    start_block(1, 1, NR + 1, 1'b0);
    drain(100);

    // asynchronous reset during MIX_WAIT of round 5
    start_block(1, 1, 5, 1'b0);
    n = 0;
    while (!(colmix_start_out && round_out == 4'd5) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reached_mix_round5", int'(n < 100), 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midblock_reset");
    chk("pre_reset_arks_seen", sb.size(), 0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    start_block(1, 1, NR + 1, 1'b0);
    drain(100);

    // start held high: two blocks back-to-back with one IDLE cycle between
    b = cyc;
    push_block(b, 1, 1, NR + 1, 1'b0);
    push_block(b + 51, 1, 1, NR + 1, 1'b0);
    start_in = 1'b1;
    en_de_in = 1'b1;
    while (cyc < b + 52) begin
      @(posedge clk); #1;
    end
    start_in = 1'b0;
    drain(100);

    // readies 3 cycles late plus spurious colmix ready inside SUB_WAIT
    dly  = 3;
    spur = 1'b1;
    start_block(1, 3, NR + 1, 1'b0);
    drain(200);
    spur = 1'b0;
    dly  = 1;

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
